// File: rtl/fb_scanout.sv
// fb_scanout: 640x480@60 VGA scanout of a 40x30 monochrome framebuffer shown as 16x16 blocks.
// Define FB_SCANOUT_GRID_EN to draw a dim grid on unlit blocks.
module fb_scanout (
    input  logic          clock,
    input  logic          reset,
    input  logic [1199:0] framebuffer,
    output logic          hsync,
    output logic          vsync,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          frame_start
);

    localparam logic [9:0]  HVisible   = 10'd640;
    localparam logic [9:0]  HSyncStart = 10'd656;
    localparam logic [9:0]  HSyncEnd   = 10'd751;
    localparam logic [9:0]  HLast      = 10'd799;
    localparam logic [9:0]  VVisible   = 10'd480;
    localparam logic [9:0]  VSyncStart = 10'd490;
    localparam logic [9:0]  VSyncEnd   = 10'd491;
    localparam logic [9:0]  VLast      = 10'd524;
    localparam logic [9:0]  VLoad      = 10'd479;
    localparam logic [10:0] NumPixels  = 11'd1200;

    logic          pix_en_q;
    logic [9:0]    hcount_q;
    logic [9:0]    vcount_q;
    logic [1199:0] snapshot_q;

    logic          h_last;
    logic          v_last;
    logic          visible;
    logic          load;
    logic          in_hsync;
    logic          in_vsync;
    logic [5:0]    row;
    logic [5:0]    col;
    logic [10:0]   pix_idx;
    logic          pix_bit;
    logic [3:0]    colour;

    always_comb begin
        h_last   = (hcount_q == HLast);
        v_last   = (vcount_q == VLast);
        visible  = (hcount_q < HVisible) && (vcount_q < VVisible);
        // Latch a new image as the last visible line ends, so a frame never tears.
        load     = pix_en_q && h_last && (vcount_q == VLoad);
        in_hsync = (hcount_q >= HSyncStart) && (hcount_q <= HSyncEnd);
        in_vsync = (vcount_q >= VSyncStart) && (vcount_q <= VSyncEnd);
        row      = vcount_q[9:4];
        col      = hcount_q[9:4];
        pix_idx  = 11'(row) * 11'd40 + 11'd39 - 11'(col);
        pix_bit  = 1'b0;
        if (visible && (pix_idx < NumPixels)) begin
            pix_bit = snapshot_q[pix_idx];
        end
        colour = pix_bit ? 4'hF : 4'h0;
`ifdef FB_SCANOUT_GRID_EN
        if (visible && !pix_bit && ((hcount_q[3:0] == 4'd0) || (vcount_q[3:0] == 4'd0))) begin
            colour = 4'h3;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_en_q    <= 1'b0;
            hcount_q    <= '0;
            vcount_q    <= '0;
            snapshot_q  <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            pix_en_q <= ~pix_en_q;
            if (pix_en_q) begin
                hcount_q <= h_last ? 10'd0 : hcount_q + 10'd1;
                if (h_last) begin
                    vcount_q <= v_last ? 10'd0 : vcount_q + 10'd1;
                end
            end
            if (load) begin
                snapshot_q <= framebuffer;
            end
            frame_start <= load;
            hsync       <= ~in_hsync;
            vsync       <= ~in_vsync;
            vga_r       <= colour;
            vga_g       <= colour;
            vga_b       <= colour;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: stimulus pushes expected frame summaries and frame_start
// times; a negedge monitor measures sync timing and lit regions and pops/compares.
module tb_fb_scanout;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1199:0] framebuffer = '0;
    logic          hsync;
    logic          vsync;
    logic [3:0]    vga_r;
    logic [3:0]    vga_g;
    logic [3:0]    vga_b;
    logic          frame_start;

    fb_scanout dut (
        .clock       (clock),
        .reset       (reset),
        .framebuffer (framebuffer),
        .hsync       (hsync),
        .vsync       (vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    always #10 clock = ~clock;

    typedef struct {
        int lit;
        int min_h;
        int max_h;
        int min_v;
        int max_v;
    } frame_t;

    localparam int Frame = 840000;
    localparam int Load0 = 768000;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    logic   rst_d    = 1'b1;
    frame_t frame_q[$];
    int     fs_q[$];
    int     hs_first_q[$];

    // Cycle index since reset release; cycle 0 is the first cycle with counters free.
    always @(posedge clock) begin
        rst_d <= reset;
        cyc   <= reset ? 0 : cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic frame_t mk(int lit, int min_h, int max_h, int min_v, int max_v);
        frame_t f;
        f.lit   = lit;
        f.min_h = min_h;
        f.max_h = max_h;
        f.min_v = min_v;
        f.max_v = max_v;
        return f;
    endfunction

    // Monitor state
    int     p, ph, pv;
    int     lit, min_h, max_h, min_v, max_v, bad_col;
    int     hs_fall, vs_fall;
    logic   prev_hs, prev_vs, first_hs;
    frame_t exp_f;

    task automatic clear_stats();
        lit     = 0;
        min_h   = 9999;
        max_h   = -1;
        min_v   = 9999;
        max_v   = -1;
        bad_col = 0;
    endtask

    always @(negedge clock) begin
        if (rst_d) begin
            check("reset_hsync", 64'(hsync), 64'd1);
            check("reset_vsync", 64'(vsync), 64'd1);
            check("reset_rgb", 64'({vga_r, vga_g, vga_b}), 64'd0);
            check("reset_frame_start", 64'(frame_start), 64'd0);
            clear_stats();
            prev_hs  = 1'b1;
            prev_vs  = 1'b1;
            first_hs = 1'b1;
            hs_fall  = -1;
            vs_fall  = -1;
        end else begin
            // Outputs in cycle c reflect the counters of cycle c-1.
            p  = (cyc - 1) / 2;
            ph = p % 800;
            pv = (p / 800) % 525;
            if (frame_start) begin
                if (fs_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_start_unexpected: pulse at cycle %0d, none expected", cyc);
                end else begin
                    check("frame_start_cycle", 64'(cyc), 64'(fs_q.pop_front()));
                end
            end
            if (!((vga_r == vga_g) && (vga_g == vga_b) && ((vga_r == 4'h0) || (vga_r == 4'hF)))) begin
                bad_col++;
            end
            if (vga_r == 4'hF) begin
                lit++;
                if (ph < min_h) min_h = ph;
                if (ph > max_h) max_h = ph;
                if (pv < min_v) min_v = pv;
                if (pv > max_v) max_v = pv;
            end
            if (prev_hs && !hsync) begin
                check("hsync_fall_hcount", 64'(ph), 64'd656);
                if (first_hs) begin
                    if (hs_first_q.size() != 0) begin
                        check("hsync_first_fall_cycle", 64'(cyc), 64'(hs_first_q.pop_front()));
                    end
                    first_hs = 1'b0;
                end else begin
                    check("hsync_period", 64'(cyc - hs_fall), 64'd1600);
                end
                hs_fall = cyc;
            end
            if (!prev_hs && hsync && (hs_fall >= 0)) begin
                check("hsync_low_width", 64'(cyc - hs_fall), 64'd192);
            end
            if (prev_vs && !vsync) begin
                check("vsync_fall_position", 64'(pv * 800 + ph), 64'(490 * 800));
                if (vs_fall >= 0) begin
                    check("vsync_period", 64'(cyc - vs_fall), 64'(Frame));
                end
                vs_fall = cyc;
                if (frame_q.size() != 0) begin
                    exp_f = frame_q.pop_front();
                    check("frame_lit_clocks", 64'(lit), 64'(exp_f.lit));
                    check("frame_min_hcount", 64'(min_h), 64'(exp_f.min_h));
                    check("frame_max_hcount", 64'(max_h), 64'(exp_f.max_h));
                    check("frame_min_vcount", 64'(min_v), 64'(exp_f.min_v));
                    check("frame_max_vcount", 64'(max_v), 64'(exp_f.max_v));
                    check("frame_colour_levels", 64'(bad_col), 64'd0);
                end
                clear_stats();
            end
            if (!prev_vs && vsync && (vs_fall >= 0)) begin
                check("vsync_low_width", 64'(cyc - vs_fall), 64'd3200);
            end
            prev_hs = hsync;
            prev_vs = vsync;
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    initial begin
        frame_t black;
        frame_t white;
        int     budget;
        black = mk(0, 9999, -1, 9999, -1);
        white = mk(640 * 480 * 2, 0, 639, 0, 479);

        // Top-left pixel only: frame 0 shows the cleared snapshot, frame 1 the block.
        framebuffer     = '0;
        framebuffer[39] = 1'b1;
        frame_q.push_back(black);
        frame_q.push_back(mk(512, 0, 15, 0, 15));
        fs_q.push_back(Load0);
        hs_first_q.push_back(1313);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Bottom-right pixel (row 29, col 39) for frame 2.
        wait_cyc(800000);
        framebuffer       = '0;
        framebuffer[1160] = 1'b1;
        frame_q.push_back(mk(512, 624, 639, 464, 479));
        fs_q.push_back(Load0 + Frame);

        // All ones for frame 3, then clear while frame 3 is at vcount=100.
        wait_cyc(1640000);
        framebuffer = '1;
        frame_q.push_back(white);
        fs_q.push_back(Load0 + 2 * Frame);

        wait_cyc(3 * Frame + 100 * 1600);
        framebuffer = '0;
        frame_q.push_back(black);
        fs_q.push_back(Load0 + 3 * Frame);

        // White snapshot for frame 5, then reset inside its visible area (vcount=200).
        wait_cyc(3300000);
        framebuffer = '1;
        fs_q.push_back(Load0 + 4 * Frame);

        wait_cyc(2 * (5 * 420000 + 200 * 800 + 300));
        reset = 1'b1;
        frame_q.push_back(black);
        fs_q.push_back(Load0);
        hs_first_q.push_back(1313);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        budget = 0;
        while ((frame_q.size() != 0) && (budget < 900000)) begin
            @(negedge clock);
            budget++;
        end
        if (frame_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: %0d frame summaries never seen", frame_q.size());
        end
        repeat (4) @(negedge clock);
        check("frame_start_pending", 64'(fs_q.size()), 64'd0);
        check("hsync_first_pending", 64'(hs_first_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
